// File: rtl/zap_fetch_queue.sv
// Show-ahead fetch queue feeding zap_decode_main: captures fetched words with PC,
// predictor state and abort flag, and presents the oldest entry to decode.
module zap_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_instruction,
  input  logic [31:0] i_fetch_pc,
  input  logic [1:0]  i_fetch_taken,
  input  logic        i_fetch_abt,
  output logic [35:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic [1:0]  o_taken,
  output logic        o_abt,
  output logic        o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  taken;
    logic        abt;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic   flush_taken;
  logic   hold;
  logic   push;
  logic   pop;
  logic   not_empty;
  entry_t head;

  // data_stall sits above clear_from_alu in decode's chain, so it masks that flush.
  assign flush_taken = i_clear_from_writeback | (i_clear_from_alu & ~i_data_stall);
  assign hold        = i_data_stall | i_stall_from_shifter | i_stall_from_issue;
  assign not_empty   = (count != '0);
  assign push        = i_fetch_valid & (count < FULL_CNT) & ~flush_taken;
  assign pop         = ~flush_taken & ~hold & not_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_taken) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // Entry storage needs no reset; contents are only observed when count != 0.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) begin
      mem[wr_ptr] <= '{instr: i_fetch_instruction, pc: i_fetch_pc,
                       taken: i_fetch_taken, abt: i_fetch_abt};
    end
  end

  always_comb begin
    head = '0;
    if (not_empty) head = mem[rd_ptr];
  end

  assign o_instruction       = {4'b0000, head.instr};
  assign o_instruction_valid = not_empty;
  assign o_pc_ff             = head.pc;
  assign o_pc_plus_8_ff      = head.pc + 32'd8;
  assign o_taken             = head.taken;
  assign o_abt               = head.abt;
  assign o_full              = (count == FULL_CNT);
  assign o_count             = count;

endmodule

// File: tb/tb_zap_fetch_queue.sv
// Directed self-checking bench for zap_fetch_queue (DEPTH = 4).
module tb_zap_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_wb, dstall, clr_alu, st_sh, st_is;
  logic        fv;
  logic [31:0] finstr, fpc;
  logic [1:0]  ftaken;
  logic        fabt;
  logic [35:0] instr;
  logic        valid;
  logic [31:0] pc, pc8;
  logic [1:0]  taken;
  logic        abt, full;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  zap_fetch_queue #(.DEPTH(4)) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_clear_from_writeback (clr_wb),
    .i_data_stall           (dstall),
    .i_clear_from_alu       (clr_alu),
    .i_stall_from_shifter   (st_sh),
    .i_stall_from_issue     (st_is),
    .i_fetch_valid          (fv),
    .i_fetch_instruction    (finstr),
    .i_fetch_pc             (fpc),
    .i_fetch_taken          (ftaken),
    .i_fetch_abt            (fabt),
    .o_instruction          (instr),
    .o_instruction_valid    (valid),
    .o_pc_ff                (pc),
    .o_pc_plus_8_ff         (pc8),
    .o_taken                (taken),
    .o_abt                  (abt),
    .o_full                 (full),
    .o_count                (count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 0; clr_wb = 0; dstall = 0; clr_alu = 0; st_sh = 0; st_is = 0;
    fv = 0; finstr = '0; fpc = '0; ftaken = '0; fabt = 0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (instr !== 36'h0 || pc !== 32'h0) begin failures++; $display("FAIL reset_head got instr=%h pc=%h exp 0/0", instr, pc); end
    checks++; if (pc8 !== 32'd8) begin failures++; $display("FAIL reset_pc8 got %h exp 8", pc8); end
    checks++; if (taken !== 2'b00 || abt !== 1'b0) begin failures++; $display("FAIL reset_flags got taken=%b abt=%b exp 00/0", taken, abt); end
  endtask

  task automatic test_single;
    idle();
    fv = 1; finstr = 32'hE3A00001; fpc = 32'h100;
    tick();
    fv = 0;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b exp 1", valid); end
    checks++; if (instr !== 36'h0E3A00001) begin failures++; $display("FAIL single_instr got %h exp 0E3A00001", instr); end
    checks++; if (pc !== 32'h100 || pc8 !== 32'h108) begin failures++; $display("FAIL single_pc got %h/%h exp 100/108", pc, pc8); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got %0d exp 1", count); end
    tick();
    checks++; if (count !== 3'd0 || valid !== 1'b0) begin failures++; $display("FAIL single_pop got count=%0d valid=%b exp 0/0", count, valid); end
  endtask

  task automatic test_fill_full;
    idle();
    st_is = 1;
    for (int i = 0; i < 5; i++) begin
      fv = 1; fpc = 32'(4 * i); finstr = 32'hA0000000 + 32'(i);
      tick();
      if (i == 3) begin
        checks++; if (full !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL fill_full got full=%b count=%0d exp 1/4", full, count); end
      end
    end
    fv = 0;
    checks++; if (count !== 3'd4 || pc !== 32'h0) begin failures++; $display("FAIL fill_drop got count=%0d pc=%h exp 4/0", count, pc); end
    st_is = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * i) || instr !== {4'h0, 32'hA0000000 + 32'(i)}) begin
        failures++; $display("FAIL drain_%0d got valid=%b pc=%h instr=%h exp 1/%h/%h", i, valid, pc, instr, 4 * i, 32'hA0000000 + 32'(i));
      end
      tick();
    end
    checks++; if (count !== 3'd0 || valid !== 1'b0) begin failures++; $display("FAIL drain_empty got count=%0d valid=%b exp 0/0", count, valid); end
  endtask

  task automatic test_priority;
    idle();
    st_is = 1;
    for (int i = 0; i < 4; i++) begin
      fv = 1; fpc = 32'h200 + 32'(4 * i); finstr = 32'h11110000 + 32'(i);
      tick();
    end
    fv = 0; st_is = 0; dstall = 1; clr_alu = 1;
    tick();
    checks++; if (count !== 3'd4 || pc !== 32'h200) begin failures++; $display("FAIL dstall_masks_alu got count=%0d pc=%h exp 4/200", count, pc); end
    dstall = 0; clr_alu = 0; clr_wb = 1; fv = 1; fpc = 32'h900;
    tick();
    clr_wb = 0; fv = 0;
    checks++; if (count !== 3'd0 || valid !== 1'b0 || pc8 !== 32'd8) begin failures++; $display("FAIL wb_flush got count=%0d valid=%b pc8=%h exp 0/0/8", count, valid, pc8); end
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL wb_push_discard got count=%0d exp 0", count); end
    st_sh = 1;
    for (int i = 0; i < 2; i++) begin
      fv = 1; fpc = 32'h300 + 32'(4 * i);
      tick();
    end
    fv = 0; clr_alu = 1;
    tick();
    clr_alu = 0; st_sh = 0;
    checks++; if (count !== 3'd0 || valid !== 1'b0) begin failures++; $display("FAIL alu_over_shifter got count=%0d valid=%b exp 0/0", count, valid); end
  endtask

  task automatic test_stream;
    idle();
    fv = 1; fpc = 32'h0; finstr = 32'h5000_0000;
    tick();
    for (int k = 1; k <= 12; k++) begin
      fpc = 32'(4 * k); finstr = 32'h5000_0000 + 32'(k);
      tick();
      checks++;
      if (count !== 3'd1 || pc !== 32'(4 * k) || instr[31:0] !== 32'h5000_0000 + 32'(k)) begin
        failures++; $display("FAIL stream_%0d got count=%0d pc=%h instr=%h exp 1/%h/%h", k, count, pc, instr, 4 * k, 32'h5000_0000 + 32'(k));
      end
    end
    fv = 0;
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_end got count=%0d exp 0", count); end
  endtask

  task automatic test_abort;
    idle();
    fv = 1; fpc = 32'hFFFFFFFC; finstr = 32'hDEADBEEF; ftaken = 2'b10; fabt = 1;
    tick();
    idle();
    checks++; if (abt !== 1'b1 || taken !== 2'b10) begin failures++; $display("FAIL abort_flags got abt=%b taken=%b exp 1/10", abt, taken); end
    checks++; if (pc8 !== 32'h4 || pc !== 32'hFFFFFFFC) begin failures++; $display("FAIL abort_pc_wrap got pc=%h pc8=%h exp FFFFFFFC/4", pc, pc8); end
    checks++; if (instr !== 36'h0DEADBEEF) begin failures++; $display("FAIL abort_instr got %h exp 0DEADBEEF", instr); end
    tick();
    checks++; if (valid !== 1'b0 || abt !== 1'b0 || taken !== 2'b00) begin failures++; $display("FAIL abort_drain got valid=%b abt=%b taken=%b exp 0/0/00", valid, abt, taken); end
  endtask

  task automatic test_full_pop_push;
    idle();
    st_is = 1;
    for (int i = 0; i < 4; i++) begin
      fv = 1; fpc = 32'h400 + 32'(4 * i);
      tick();
    end
    st_is = 0; fv = 1; fpc = 32'h7770;
    tick();
    fv = 0;
    checks++; if (count !== 3'd3 || full !== 1'b0 || pc !== 32'h404) begin failures++; $display("FAIL full_pop_push got count=%0d full=%b pc=%h exp 3/0/404", count, full, pc); end
    tick(); tick();
    checks++; if (count !== 3'd1 || pc !== 32'h40C) begin failures++; $display("FAIL full_push_dropped got count=%0d pc=%h exp 1/40C", count, pc); end
    tick();
  endtask

  task automatic test_reset_mid;
    idle();
    st_is = 1;
    for (int i = 0; i < 3; i++) begin
      fv = 1; fpc = 32'h500 + 32'(4 * i);
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_prefill got count=%0d exp 3", count); end
    rst = 1; fpc = 32'h600;
    tick();
    idle();
    checks++; if (count !== 3'd0 || valid !== 1'b0 || pc8 !== 32'd8) begin failures++; $display("FAIL mid_reset got count=%0d valid=%b pc8=%h exp 0/0/8", count, valid, pc8); end
    tick();
    checks++; if (count !== 3'd0 || valid !== 1'b0) begin failures++; $display("FAIL mid_reset_push_lost got count=%0d valid=%b exp 0/0", count, valid); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_fill_full();
    test_priority();
    test_stream();
    test_abort();
    test_full_pop_push();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
